// File: rtl/alu_seq_accumulator_if.sv
// Request/result bundle between the register file, the sequential ALU and writeback.
// The master drives operands and opcode; the slave (the ALU) returns accumulator and flags.
interface alu_seq_accumulator_if #(
    parameter int WIDTH = 16
);
    logic             iValid;
    logic             oReady;
    logic [2:0]       iOpcode;
    logic             iUseAcc;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic [WIDTH-1:0] oAccumulator;
    logic             oValid;
    logic             oCarry;
    logic             oZero;
    logic             oNegative;
    logic             oOverflow;

    modport master (
        output iValid, iOpcode, iUseAcc, iA, iB,
        input  oReady, oAccumulator, oValid, oCarry, oZero, oNegative, oOverflow
    );

    modport slave (
        input  iValid, iOpcode, iUseAcc, iA, iB,
        output oReady, oAccumulator, oValid, oCarry, oZero, oNegative, oOverflow
    );
endinterface

// File: rtl/alu_seq_accumulator.sv
// Sequential ALU with registered accumulator and flags; single-cycle logic/add/sub
// plus a WIDTH-cycle shift-add multiply.
module alu_seq_accumulator #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_ACC = '0
) (
    input  logic                 iClock,
    input  logic                 iReset,
    alu_seq_accumulator_if.slave bus
);
    // state  | meaning
    // IDLE   | ready; single-cycle ops complete at the accepting edge
    // MUL    | shift-add multiply in progress, one multiplier bit per edge
    typedef enum logic {S_IDLE, S_MUL} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;
    logic               r_valid;
    logic               r_ready;
    logic [WIDTH-1:0]   r_mul_a;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    always_comb begin
        w_a     = bus.iUseAcc ? r_acc : bus.iA;
        w_b     = bus.iB;
        w_add   = {1'b0, w_a} + {1'b0, w_b};
        w_sub   = {1'b0, w_a} - {1'b0, w_b};
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.iOpcode)
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_NOT:  w_res = ~w_a;
            OP_PASS: w_res = w_b;
            OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            default: w_res = '0;
        endcase
    end

    // Multiplier sits in the low half of r_prod and is consumed LSB-first as the
    // partial product shifts in from the top.
    always_comb begin
        w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mul_a} : '0);
        w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_acc   <= RESET_ACC;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_mul_a <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.iValid) begin
                        if (bus.iOpcode == OP_MUL) begin
                            r_mul_a <= w_a;
                            r_prod  <= {{WIDTH{1'b0}}, w_b};
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_MUL;
                            r_ready <= 1'b0;
                        end else begin
                            r_acc   <= w_res;
                            r_carry <= w_carry;
                            r_ovf   <= w_ovf;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[WIDTH-1];
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_prod <= w_mul_next;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_acc   <= w_mul_next[WIDTH-1:0];
                        r_carry <= |w_mul_next[2*WIDTH-1:WIDTH];
                        r_ovf   <= 1'b0;
                        r_zero  <= (w_mul_next[WIDTH-1:0] == '0);
                        r_neg   <= w_mul_next[WIDTH-1];
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.oAccumulator = r_acc;
    assign bus.oCarry       = r_carry;
    assign bus.oZero        = r_zero;
    assign bus.oNegative    = r_neg;
    assign bus.oOverflow    = r_ovf;
    assign bus.oValid       = r_valid;
    assign bus.oReady       = r_ready;
endmodule
